// File: rtl/shift_seq.sv
// Sequential barrel-free shifter: applies LSL/LSR/ASR/ROL/ROR to a loaded operand
// in coarse steps of d bits, then single-bit steps, with a one-cycle done pulse.
module shift_seq #(
  parameter int unsigned w = 64,
  parameter int unsigned d = 4
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic [$clog2(w)-1:0] amt,
  input  logic [w-1:0]         in,
  output logic                 busy,
  output logic                 done,
  output logic [w-1:0]         q
);

  localparam int unsigned aw = $clog2(w);
  localparam logic [aw-1:0] step_big = aw'(d);
  localparam logic [aw-1:0] step_one = aw'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  logic [2:0]    op;
  logic [aw-1:0] rem;
  logic [aw-1:0] step;
  logic [w-1:0]  shifted;

  always_comb begin
    step    = (rem >= step_big) ? step_big : step_one;
    shifted = q;
    case (op)
      3'b000:  shifted = q << step;
      3'b001:  shifted = q >> step;
      3'b010:  shifted = $signed(q) >>> step;
      3'b011:  shifted = (q << step) | (q >> (w - 32'(step)));
      3'b100:  shifted = (q >> step) | (q << (w - 32'(step)));
      default: shifted = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      op    <= '0;
      rem   <= '0;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            q    <= in;
            op   <= mode;
            rem  <= amt;
            busy <= 1'b1;
            // Zero amount and reserved modes skip SHIFT so q stays equal to in.
            if (amt == '0 || mode > 3'b100) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          q   <= shifted;
          rem <= rem - step;
          if (rem == step) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Randomized self-checking bench for shift_seq against a bit-at-a-time reference model.
module tb_shift_seq;

  localparam int unsigned W = 64;
  localparam int unsigned D = 4;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          start;
  logic [2:0]    mode;
  logic [5:0]    amt;
  logic [W-1:0]  in;
  logic          busy;
  logic          done;
  logic [W-1:0]  q;

  int checks = 0;
  int errors = 0;

  shift_seq #(.w(W), .d(D)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .start (start),
    .mode  (mode),
    .amt   (amt),
    .in    (in),
    .busy  (busy),
    .done  (done),
    .q     (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_q(input logic [2:0] m, input int unsigned a,
                                          input logic [63:0] x);
    logic [63:0] r;
    r = x;
    for (int unsigned i = 0; i < a; i++) begin
      case (m)
        3'd0:    r = {r[62:0], 1'b0};
        3'd1:    r = {1'b0, r[63:1]};
        3'd2:    r = {r[63], r[63:1]};
        3'd3:    r = {r[62:0], r[63]};
        3'd4:    r = {r[0], r[63:1]};
        default: r = r;
      endcase
    end
    return r;
  endfunction

  function automatic int unsigned model_n(input logic [2:0] m, input int unsigned a);
    if (m > 3'd4) return 0;
    return a / D + a % D;
  endfunction

  // Call with time just past a rising edge; returns just past the edge where DUT is IDLE again.
  task automatic run_op(input logic [2:0] m, input int unsigned a, input logic [63:0] x,
                        input bit noise);
    logic [63:0] exp_q;
    int unsigned n;
    int unsigned cnt;
    exp_q = model_q(m, a, x);
    n     = model_n(m, a);
    start = 1'b1;
    mode  = m;
    amt   = 6'(a);
    in    = x;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 3'($urandom);
    amt   = 6'($urandom);
    in    = {$urandom, $urandom};
    check("busy_accept", busy, 1);
    cnt = 0;
    while (!done && cnt <= n + 2) begin
      check("busy_shift", busy, 1);
      if (noise) begin
        start = 1'($urandom);
        in    = {$urandom, $urandom};
        mode  = 3'($urandom);
        amt   = 6'($urandom);
      end
      @(posedge clk); #1;
      cnt++;
    end
    start = 1'b0;
    check("latency", 64'(cnt), 64'(n));
    check("q_result", q, exp_q);
    check("busy_done", busy, 1);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    check("q_hold", q, exp_q);
  endtask

  initial begin
    bit saw_done;
    rst_b = 1'b0;
    start = 1'b0;
    mode  = '0;
    amt   = '0;
    in    = '0;
    #2;
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 5, 64'h1, 1'b0);
    run_op(3'd2, 63, 64'h8000_0000_0000_0000, 1'b0);
    run_op(3'd4, 1, 64'h1, 1'b0);
    run_op(3'd1, 4, 64'hF0, 1'b0);
    for (int m = 0; m < 5; m++) run_op(3'(m), 0, 64'h1234, 1'b0);
    run_op(3'd5, 7, 64'h1234, 1'b0);
    run_op(3'd7, 63, 64'hDEAD_BEEF_0000_1234, 1'b0);
    run_op(3'd3, 61, 64'h0123_4567_89AB_CDEF, 1'b1);

    // Abort mid-shift with an asynchronous reset.
    start = 1'b1; mode = 3'd2; amt = 6'd63; in = 64'h8000_0000_0000_0001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    check("abort_q", q, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst_b = 1'b1;
    saw_done = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 0);
    check("abort_idle", busy, 0);
    run_op(3'd3, 9, 64'h8000_0000_0000_0001, 1'b0);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), $urandom_range(0, 63), {$urandom, $urandom}, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter w, default 64, operand/result width in bits (power of two, 8..64).
REQ-002 Parameter d, default 4, bits shifted per coarse step (1 <= d < w).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_b  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled on rising clk, accepted only in IDLE.
REQ-006 mode  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101-111 reserved.
REQ-007 amt  input  $clog2(w)  shift amount, unsigned, 0..w-1.
REQ-008 in  input  w  operand, signed interpretation for ASR only.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 q  output  w  working/result register, valid when done=1, held until next accepted start.

Function
REQ-012 The block SHALL implement three states: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 at edge k SHALL load q<=in and capture mode and rem<=amt.
REQ-014 At edge k, amt=0 or reserved mode SHALL go to DONE; otherwise go to SHIFT.
REQ-015 Each SHIFT cycle SHALL shift q by d when rem>=d, else by 1, and decrement rem by that step.
REQ-016 SHIFT SHALL go to DONE on the edge where rem reaches 0.
REQ-017 Shift SHALL take N = floor(amt/d) + (amt mod d) cycles; done SHALL be high between edge k+N and k+N+1.
REQ-018 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-019 LSL SHALL fill zeros at LSB; LSR SHALL fill zeros at MSB; ASR SHALL replicate q[w-1].
REQ-020 ROL/ROR SHALL rotate bits end-around, with no bit lost or inserted.
REQ-021 Reserved modes SHALL leave q equal to in.
REQ-022 start in SHIFT or DONE SHALL be ignored; captured mode/amt/q SHALL be unaffected.
REQ-023 Changes on in, mode, amt outside the accepting edge SHALL have no effect.
REQ-024 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE; done SHALL never be high while state is SHIFT.
REQ-025 Back-to-back operation: start may be accepted in the cycle after done (IDLE), no idle gap otherwise required.

Reset
REQ-026 rst_b=0 SHALL immediately, without clock, force state IDLE, q=0, rem=0, busy=0, done=0.
REQ-027 Reset during SHIFT or DONE SHALL abort the operation with no done pulse after release.
REQ-028 After rst_b rises, the first rising edge with start=1 SHALL be accepted normally.

Verification (w=64, d=4; start accepted at edge k)
REQ-029 LSL, in=0x1, amt=5 -> N=2; done high after edge k+2; q=0x20; busy high from edge k to k+3.
REQ-030 ASR, in=0x8000_0000_0000_0000, amt=63 -> N=18; done after edge k+18; q=0xFFFF_FFFF_FFFF_FFFF.
REQ-031 ROR, in=0x1, amt=1 -> N=1; q=0x8000_0000_0000_0000; then LSR, in=0xF0, amt=4 -> q=0x0F, N=1.
REQ-032 amt=0 (any valid mode), in=0x1234 -> done after edge k, q=0x1234; mode=101, amt=7 -> same response.
REQ-033 start pulsed with new in during SHIFT -> ignored; result matches first operation.
REQ-034 rst_b low mid-SHIFT -> q=0, busy=0, done=0 at once; no done pulse after release; next start completes correctly.
